// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Writeback-side producer for the 32x32 register-file write port. Completed
// results from execute/memory are buffered in a DEPTH-entry circular FIFO.
// At most one register-file write is issued per cycle. Queued values that are
// not yet written can be forwarded to the two register-file read addresses.
//
// Configuration macro: WBQ_FWD_EN
//   defined   -> forwarding match/select logic is compiled in
//   undefined -> fwd*_hit / fwd*_data are tied to zero (ports remain)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   in_valid   producer presents a result
//   in_ready   queue can accept (= !full)
//   in_rd      destination register of the result (rd==0 is accepted, dropped)
//   in_data    result value
//   stall      1 = inhibit draining this cycle
//   regWrite   register-file write enable (= !empty && !stall)
//   WR / D     register-file write address / data (head entry, 0 when empty)
//   Rreg1/2    register-file read addresses, used for forwarding lookup
//   fwdK_hit   a queued entry targets RregK
//   fwdK_data  youngest queued value for RregK
//   count      occupied entries
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_rd,
   input  logic [XLEN-1:0]        in_data,
   input  logic                   stall,
   output logic                   regWrite,
   output logic [4:0]             WR,
   output logic [XLEN-1:0]        D,
   input  logic [4:0]             Rreg1,
   input  logic [4:0]             Rreg2,
   output logic                   fwd1_hit,
   output logic [XLEN-1:0]        fwd1_data,
   output logic                   fwd2_hit,
   output logic [XLEN-1:0]        fwd2_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Queue storage and pointers
   logic [4:0]       r_rd   [DEPTH];
   logic [XLEN-1:0]  r_data [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count_nxt;

   // Occupancy flags; count alone distinguishes full from empty when pointers meet
   always_comb begin
      w_empty  = (r_count == CNT_ZERO);
      w_full   = (r_count == CNT_FULL);
      empty    = w_empty;
      full     = w_full;
      count    = r_count;
      in_ready = !w_full;
   end

   // Accept/drain decisions; an rd==0 result is handshaken but never stored
   always_comb begin
      w_push = in_valid && !w_full && (in_rd != 5'd0);
      w_pop  = !w_empty && !stall;
   end

   // Register-file write port driven from the head entry
   always_comb begin
      regWrite = 1'b0;
      WR       = 5'd0;
      D        = {XLEN{1'b0}};
      if (!w_empty) begin
         regWrite = !stall;
         WR       = r_rd[r_head];
         D        = r_data[r_head];
      end else begin
         regWrite = 1'b0;
         WR       = 5'd0;
         D        = {XLEN{1'b0}};
      end
   end

   // Next occupancy: simultaneous push and pop leave the count unchanged
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Queue state: pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= PTR_ZERO;
         r_tail  <= PTR_ZERO;
         r_count <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= 5'd0;
            r_data[i] <= {XLEN{1'b0}};
         end
      end else begin
         r_count <= w_count_nxt;
         if (w_pop) begin
            r_head <= r_head + PTR_ONE;
         end
         if (w_push) begin
            r_rd[r_tail]   <= in_rd;
            r_data[r_tail] <= in_data;
            r_tail         <= r_tail + PTR_ONE;
         end
      end
   end

`ifdef WBQ_FWD_EN
   logic [PTR_W-1:0] w_idx;
   logic             w_m1;
   logic             w_m2;

   // Forwarding lookup: walk from oldest (head) to youngest, so the last
   // match seen is the youngest one. The head entry being written this
   // cycle is still occupied and therefore still matches.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = {XLEN{1'b0}};
      fwd2_hit  = 1'b0;
      fwd2_data = {XLEN{1'b0}};
      w_idx     = PTR_ZERO;
      w_m1      = 1'b0;
      w_m2      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx     = r_head + PTR_W'(i);
         w_m1      = (CNT_W'(i) < r_count) && (Rreg1 != 5'd0) && (r_rd[w_idx] == Rreg1);
         w_m2      = (CNT_W'(i) < r_count) && (Rreg2 != 5'd0) && (r_rd[w_idx] == Rreg2);
         fwd1_hit  = fwd1_hit | w_m1;
         fwd2_hit  = fwd2_hit | w_m2;
         fwd1_data = w_m1 ? r_data[w_idx] : fwd1_data;
         fwd2_data = w_m2 ? r_data[w_idx] : fwd2_data;
      end
   end
`else
   logic w_unused_rreg;

   // Forwarding compiled out: outputs held at zero, read addresses ignored
   always_comb begin
      fwd1_hit      = 1'b0;
      fwd1_data     = {XLEN{1'b0}};
      fwd2_hit      = 1'b0;
      fwd2_data     = {XLEN{1'b0}};
      w_unused_rreg = ^{Rreg1, Rreg2};
   end
`endif

endmodule
